data_memory_be: RTL
===================

Name: data_memory_be

Overview:
- Parametrised successor to the single-width data memory. Synchronous single-port RAM with configurable word width and depth, per-byte write enables, and a registered read with a valid strobe.
- Adds a hardware clear sequencer: after reset, the whole array is zeroed one word per cycle.
- Flags out-of-range and misaligned accesses.
- Sits on the datapath's load/store stage, between ALU address output and writeback mux.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8, minimum 8.
- DEPTH, 256: number of words; must be a power of two, minimum 2.
- ADDR_W, 32: width of the byte address bus.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- WR  input  1  write request.
- RD  input  1  read request.
- ADDRESS  input  ADDR_W  byte address.
- BIN  input  DATA_W  write data.
- BE  input  DATA_W/8  byte enables; bit k covers BIN[8k+7:8k].
- DATAOUT  output  DATA_W  registered read data.
- RVALID  output  1  one-cycle pulse; DATAOUT is valid for a read.
- BUSY  output  1  high while the clear sequence is running.
- ERR  output  1  one-cycle pulse; the previous request was rejected.

Behaviour:
- Reset is synchronous and active-high, sampled on clk.
  - While reset=1: DATAOUT=0, RVALID=0, ERR=0, BUSY=1, clear pointer=0, state=CLEAR.
- State machine has two states, CLEAR and IDLE.
  - CLEAR: each cycle writes 0 to mem[ptr], then ptr=ptr+1.
  - When ptr==DEPTH-1 is written, the next state is IDLE and BUSY drops on that same edge.
  - From reset deassertion to BUSY=0 is exactly DEPTH cycles.
  - IDLE: services requests. The only exit is reset.
- Reset asserted mid-clear restarts the sweep at word 0. There is no partial resume.
- While BUSY=1, WR and RD are ignored: no array update, no RVALID, no ERR.
- Address decode:
  - Word index = ADDRESS >> log2(DATA_W/8).
  - Misaligned: any of the low log2(DATA_W/8) bits are nonzero.
  - Out of range: word index >= DEPTH.
  - A misaligned or out-of-range request gets no write, no RVALID, and ERR=1 on the next cycle. DATAOUT holds its value.
- Write (IDLE, WR=1, valid address):
  - Only bytes with BE[k]=1 are updated, on the clock edge.
  - BE=0 is a legal no-op; ERR stays 0.
- Read (IDLE, RD=1, valid address):
  - DATAOUT = mem[index] on the next edge, with RVALID=1 for one cycle. Latency is 1.
  - DATAOUT holds its last read value until the next valid read. It is not cleared when RVALID=0.
- WR and RD in the same cycle to the same word: read-first. DATAOUT returns pre-write data and the write still commits.
- Back-to-back reads produce RVALID on every cycle with full throughput.
- No X propagation: the array is only considered defined after the clear completes.

Test Plan:
1. Reset for 3 cycles, then release -> BUSY=1 for exactly 256 cycles, then 0. A read of byte addresses 0x0, 0x3FC and 0x200 then returns 0x00000000 with RVALID one cycle after RD.
2. After clear: WR=1, ADDRESS=0x10, BIN=0xDEADBEEF, BE=4'b1111, then RD at 0x10 -> DATAOUT=0xDEADBEEF. Then WR BIN=0x11223344, BE=4'b0101, then RD -> DATAOUT=0xDE22BE44.
3. WR=1 and RD=1 together at ADDRESS=0x10 with BIN=0x0, BE=4'hF -> DATAOUT=0xDE22BE44 (old data). A following read returns 0x00000000.
4. RD at ADDRESS=0x13 (misaligned) and at 0x400 (out of range, DEPTH=256) -> ERR pulses one cycle each, RVALID=0, DATAOUT unchanged. WR at 0x400 leaves word 0 unchanged.
5. Write 0xFFFFFFFF to all 256 words, assert reset at clear cycle 100, then release -> BUSY lasts 256 more cycles. Afterwards all words read 0. WR/RD issued during BUSY produce no RVALID, no ERR and no array change.
6. Re-elaborate with DATA_W=64, DEPTH=16 -> ADDRESS=0x8 maps to word 1, 0x4 raises ERR, BE=8'hF0 writes only the upper 32 bits, and the clear lasts 16 cycles.

Source files
------------

// File: rtl/data_memory_be.sv
// Single-port byte-enable data memory with a 1-cycle registered read and a valid strobe.
// After reset a sequencer zeroes one word per cycle (BUSY high); bad addresses raise ERR.
module data_memory_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  WR,
  input  logic                  RD,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [DATA_W-1:0]     BIN,
  input  logic [DATA_W/8-1:0]   BE,
  output logic [DATA_W-1:0]     DATAOUT,
  output logic                  RVALID,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((64'd1 << OFS_W) - 64'd1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  PTR_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0]  word_addr;
  logic [IDX_W-1:0]   idx;
  logic               bad_addr;
  logic               wr_ok;
  logic               rd_ok;
  logic               req_bad;

  assign word_addr = ADDRESS >> OFS_W;
  assign idx       = word_addr[IDX_W-1:0];
  assign bad_addr  = (|(ADDRESS & OFS_MASK)) || (word_addr >= DEPTH_A);
  assign wr_ok     = (state == IDLE) && WR && !bad_addr;
  assign rd_ok     = (state == IDLE) && RD && !bad_addr;
  assign req_bad   = (state == IDLE) && (WR || RD) && bad_addr;

  // Array has no reset; the clear sweep is what makes its contents defined.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else if (wr_ok) begin
        for (int k = 0; k < NB; k++) begin
          if (BE[k]) mem[idx][8*k +: 8] <= BIN[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      ptr     <= '0;
      BUSY    <= 1'b1;
      DATAOUT <= '0;
      RVALID  <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      RVALID <= rd_ok;
      ERR    <= req_bad;
      // Nonblocking read of the pre-edge array gives read-first on a same-word WR+RD.
      if (rd_ok) DATAOUT <= mem[idx];
      if (state == CLEAR) begin
        ptr <= ptr + 1'b1;
        if (ptr == PTR_LAST) begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      end
    end
  end

endmodule
